elevator_call_panel: RTL

Button-side front end for the elevator controller: the originator end of the request interface the arbiter consumes. It synchronizes and debounces raw floor-call buttons, holds each accepted call as a lit lamp, and emits single-cycle request pulses toward the controller's request inputs. A call is cleared when the elevator reports the matching floor with the door open; still-pending calls are re-issued periodically.

---
 rtl/elevator_call_panel.sv | 139 +++++++++++++
 1 files changed

// File: rtl/elevator_call_panel.sv
// rtl/elevator_call_panel.sv - floor-call button front end: sync, debounce, call lamps, request pulses
module elevator_call_panel #(
    parameter int FLOORS_NUM      = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REISSUE_CYCLES  = 100_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FLOORS_NUM-1:0]         btn_raw,
    input  logic [$clog2(FLOORS_NUM)-1:0] curr_floor,
    input  logic                          door,
    output logic [FLOORS_NUM-1:0]         req,
    output logic [FLOORS_NUM-1:0]         lamp
);

    localparam int FW = $clog2(FLOORS_NUM);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } call_state_e;

    logic [FLOORS_NUM-1:0] sync1_q, sync2_q;
    logic [FLOORS_NUM-1:0] stable_q, stable_prev_q;
    logic [DW-1:0]         db_cnt_q [FLOORS_NUM];
    logic [FLOORS_NUM-1:0] press;
    logic [FLOORS_NUM-1:0] served;
    logic [FLOORS_NUM-1:0] req_q, req_d;
    call_state_e           state_q [FLOORS_NUM];
    call_state_e           state_d [FLOORS_NUM];
    logic                  any_lamp;
    logic                  rs_fire;

    // Counter only runs while synchronized level disagrees with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < FLOORS_NUM; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int i = 0; i < FLOORS_NUM; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_MAX) begin
                    stable_q[i] <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

    always_comb begin
        served = '0;
        lamp   = '0;
        for (int i = 0; i < FLOORS_NUM; i++) begin
            served[i] = door && (curr_floor == FW'(i));
            lamp[i]   = (state_q[i] == PENDING);
        end
    end

    assign any_lamp = |lamp;

    generate
        if (REISSUE_CYCLES > 0) begin : g_reissue
            localparam int RW = (REISSUE_CYCLES > 1) ? $clog2(REISSUE_CYCLES) : 1;
            localparam logic [RW-1:0] RS_LAST = RW'(REISSUE_CYCLES - 1);
            logic [RW-1:0] rs_cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rs_cnt_q <= '0;
                end else if (!any_lamp || rs_cnt_q == RS_LAST) begin
                    rs_cnt_q <= '0;
                end else begin
                    rs_cnt_q <= rs_cnt_q + 1'b1;
                end
            end

            assign rs_fire = any_lamp && (rs_cnt_q == RS_LAST);
        end else begin : g_no_reissue
            assign rs_fire = 1'b0;
        end
    endgenerate

    // Service always wins over a press or a re-issue in the same cycle.
    always_comb begin
        req_d = '0;
        for (int i = 0; i < FLOORS_NUM; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (press[i] && !served[i]) begin
                        state_d[i] = PENDING;
                        req_d[i]   = 1'b1;
                    end
                end
                PENDING: begin
                    if (served[i]) begin
                        state_d[i] = IDLE;
                    end else if (rs_fire) begin
                        req_d[i] = 1'b1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
        req_d = req_d & ~req_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            for (int i = 0; i < FLOORS_NUM; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            req_q <= req_d;
            for (int i = 0; i < FLOORS_NUM; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    assign req = req_q;

endmodule
